// File: rtl/hazard_ctrl_unit_pkg.sv
// hazard_ctrl_unit_pkg: RV32I opcodes, FSM states and in-flight destination shadow type
package hazard_ctrl_unit_pkg;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_FREEZE} state_e;

    typedef struct packed {
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } shadow_t;

    localparam shadow_t SHADOW_NONE = '0;

    function automatic logic raw_hit(logic used, logic [4:0] rs, shadow_t s);
        return used && s.wr && (rs == s.rd);
    endfunction
endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// hazard_ctrl_unit_if: ID-stage inputs and pipeline control outputs of the hazard unit
interface hazard_ctrl_unit_if #(parameter int CNT_W = 16);
    logic             if_id_valid;
    logic [31:0]      if_id_inst;
    logic             br_taken;
    logic             dmem_busy;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             id_ex_flush;
    logic             freeze;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output if_id_valid, if_id_inst, br_taken, dmem_busy,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_flush, freeze, stall_cnt, flush_cnt
    );
    modport slave (
        input  if_id_valid, if_id_inst, br_taken, dmem_busy,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_flush, freeze, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl_unit_rv_src_decode.sv
// rv_src_decode: opcode -> source usage, destination write and load flags
module rv_src_decode
    import hazard_ctrl_unit_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic       rs1_used_o,
    output logic       rs2_used_o,
    output logic       rd_write_o,
    output logic       is_load_o
);
    assign rs1_used_o = opcode_i inside {OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_OP};
    assign rs2_used_o = opcode_i inside {OP_BRANCH, OP_STORE, OP_OP};
    assign rd_write_o = opcode_i inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_OP};
    assign is_load_o  = (opcode_i == OP_LOAD);
endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: load-use/RAW stalls, taken-branch flushes and DMEM-wait freezes for a 5-stage RV32I pipe
module hazard_ctrl_unit
    import hazard_ctrl_unit_pkg::*;
#(
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input logic               clk_i,
    input logic               rst_n_i,
    hazard_ctrl_unit_if.slave hz_if
);
    logic             rs1_used, rs2_used, rd_write, is_load;
    logic             use1, use2, hit_idex, hit_exmem, hit_memwb;
    logic             busy, flush, stall, stall_cond;
    logic [4:0]       rs1, rs2, rd;
    shadow_t          idex_q, exmem_q, memwb_q, idex_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    rv_src_decode u_dec (
        .opcode_i   (hz_if.if_id_inst[6:0]),
        .rs1_used_o (rs1_used),
        .rs2_used_o (rs2_used),
        .rd_write_o (rd_write),
        .is_load_o  (is_load)
    );

    assign rs1  = hz_if.if_id_inst[19:15];
    assign rs2  = hz_if.if_id_inst[24:20];
    assign rd   = hz_if.if_id_inst[11:7];
    assign use1 = hz_if.if_id_valid && rs1_used;
    assign use2 = hz_if.if_id_valid && rs2_used;

    assign hit_idex  = raw_hit(use1, rs1, idex_q)  || raw_hit(use2, rs2, idex_q);
    assign hit_exmem = raw_hit(use1, rs1, exmem_q) || raw_hit(use2, rs2, exmem_q);
    assign hit_memwb = raw_hit(use1, rs1, memwb_q) || raw_hit(use2, rs2, memwb_q);
    // without forwarding the register file is not write-through, so every older producer blocks
    assign stall_cond = FWD_EN ? (hit_idex && idex_q.ld) : (hit_idex || hit_exmem || hit_memwb);

    assign busy  = hz_if.dmem_busy;
    assign flush = hz_if.br_taken && !busy;
    assign stall = stall_cond && !busy && !hz_if.br_taken;

    assign hz_if.freeze       = busy;
    assign hz_if.pc_write     = !busy && !stall;
    assign hz_if.if_id_write  = !busy && !stall;
    assign hz_if.if_id_flush  = flush;
    assign hz_if.id_ex_flush  = flush;
    assign hz_if.id_ex_bubble = stall;
    assign hz_if.stall_cnt    = stall_cnt_q;
    assign hz_if.flush_cnt    = flush_cnt_q;

    always_comb begin
        idex_d      = (stall || flush || !hz_if.if_id_valid) ? SHADOW_NONE
                    : shadow_t'({rd, rd_write && (rd != 5'd0), is_load && rd_write && (rd != 5'd0)});
        stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        flush_cnt_d = (flush && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
        state_d     = state_q;
        case (state_q)
            ST_FREEZE: state_d = busy ? ST_FREEZE : (stall ? ST_STALL : ST_RUN);
            default:   state_d = busy ? ST_FREEZE : (stall ? ST_STALL : ST_RUN);
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_RUN;
            idex_q      <= SHADOW_NONE;
            exmem_q     <= SHADOW_NONE;
            memwb_q     <= SHADOW_NONE;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (!busy) begin
                memwb_q     <= exmem_q;
                exmem_q     <= idex_q;
                idex_q      <= idex_d;
                stall_cnt_q <= stall_cnt_d;
                flush_cnt_q <= flush_cnt_d;
            end
        end
    end
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: three configurations (forwarding, no forwarding, 4-bit counters) against a queue model
module tb_hazard_ctrl_unit;
    localparam logic [6:0] O_LOAD = 7'b0000011, O_STORE = 7'b0100011, O_BR = 7'b1100011, O_OP = 7'b0110011,
                           O_IMM = 7'b0010011, O_JAL = 7'b1101111, O_JALR = 7'b1100111, O_LUI = 7'b0110111,
                           O_AUIPC = 7'b0010111;
    localparam int FWD [3]  = '{1, 0, 1};
    localparam int MAXC [3] = '{65535, 65535, 15};

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        valid = 1'b0, br = 1'b0, busy = 1'b0;
    logic [31:0] inst = '0;
    int          n_cmp = 0, n_err = 0;
    int          m_rd [3][3];
    bit          m_ld [3][3];
    int          m_sc [3], m_fc [3];

    always #5 clk = ~clk;

    hazard_ctrl_unit_if #(.CNT_W(16)) if1 ();
    hazard_ctrl_unit_if #(.CNT_W(16)) if0 ();
    hazard_ctrl_unit_if #(.CNT_W(4))  if4 ();

    assign if1.if_id_valid = valid; assign if1.if_id_inst = inst; assign if1.br_taken = br; assign if1.dmem_busy = busy;
    assign if0.if_id_valid = valid; assign if0.if_id_inst = inst; assign if0.br_taken = br; assign if0.dmem_busy = busy;
    assign if4.if_id_valid = valid; assign if4.if_id_inst = inst; assign if4.br_taken = br; assign if4.dmem_busy = busy;

    hazard_ctrl_unit #(.FWD_EN(1'b1), .CNT_W(16)) dut1 (.clk_i(clk), .rst_n_i(rst_n), .hz_if(if1));
    hazard_ctrl_unit #(.FWD_EN(1'b0), .CNT_W(16)) dut0 (.clk_i(clk), .rst_n_i(rst_n), .hz_if(if0));
    hazard_ctrl_unit #(.FWD_EN(1'b1), .CNT_W(4))  dut4 (.clk_i(clk), .rst_n_i(rst_n), .hz_if(if4));

    function automatic logic [5:0] outs(int c);
        case (c)
            0:       return {if1.freeze, if1.pc_write, if1.if_id_write, if1.if_id_flush, if1.id_ex_bubble, if1.id_ex_flush};
            1:       return {if0.freeze, if0.pc_write, if0.if_id_write, if0.if_id_flush, if0.id_ex_bubble, if0.id_ex_flush};
            default: return {if4.freeze, if4.pc_write, if4.if_id_write, if4.if_id_flush, if4.id_ex_bubble, if4.id_ex_flush};
        endcase
    endfunction

    function automatic logic [31:0] scnt(int c);
        return (c == 0) ? 32'(if1.stall_cnt) : (c == 1) ? 32'(if0.stall_cnt) : 32'(if4.stall_cnt);
    endfunction

    function automatic logic [31:0] fcnt(int c);
        return (c == 0) ? 32'(if1.flush_cnt) : (c == 1) ? 32'(if0.flush_cnt) : 32'(if4.flush_cnt);
    endfunction

    function automatic logic [31:0] enc(logic [6:0] op, int rd, int rs1, int rs2);
        logic [4:0] d = rd[4:0], a = rs1[4:0], b = rs2[4:0];
        return {7'b0, b, a, 3'b010, d, op};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock: drive ID inputs, check every configuration against the model, then advance the model
    task automatic cyc(logic v, logic [31:0] i, logic b, logic bz);
        logic [6:0] op;
        int rs1, rs2, rd, nrd;
        bit u1, u2, wr, ld, st, fl, sb, pcw;
        valid = v; inst = i; br = b; busy = bz;
        #2;
        op = i[6:0]; rs1 = int'(i[19:15]); rs2 = int'(i[24:20]); rd = int'(i[11:7]);
        wr = op inside {O_LUI, O_AUIPC, O_JAL, O_JALR, O_LOAD, O_IMM, O_OP};
        u1 = v && (op inside {O_JALR, O_BR, O_LOAD, O_STORE, O_IMM, O_OP});
        u2 = v && (op inside {O_BR, O_STORE, O_OP});
        ld = (op == O_LOAD);
        for (int c = 0; c < 3; c++) begin
            st = 0;
            for (int k = 0; k < 3; k++)
                if ((k == 0 || FWD[c] == 0) && m_rd[c][k] != 0 && (FWD[c] == 0 || m_ld[c][k]) &&
                    ((u1 && rs1 == m_rd[c][k]) || (u2 && rs2 == m_rd[c][k]))) st = 1;
            fl  = !bz && b;
            sb  = !bz && !b && st;
            pcw = !bz && !sb;
            chk($sformatf("ctl%0d t=%0t", c, $time), 32'(outs(c)), 32'({bz, pcw, pcw, fl, sb, fl}));
            chk($sformatf("stall_cnt%0d t=%0t", c, $time), scnt(c), m_sc[c]);
            chk($sformatf("flush_cnt%0d t=%0t", c, $time), fcnt(c), m_fc[c]);
            if (!bz) begin
                nrd = (fl || sb || !v || !wr) ? 0 : rd;
                m_rd[c][2] = m_rd[c][1]; m_ld[c][2] = m_ld[c][1];
                m_rd[c][1] = m_rd[c][0]; m_ld[c][1] = m_ld[c][0];
                m_rd[c][0] = nrd;        m_ld[c][0] = ld && nrd != 0;
                if (sb && m_sc[c] < MAXC[c]) m_sc[c]++;
                if (fl && m_fc[c] < MAXC[c]) m_fc[c]++;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic rst_pulse();
        valid = 0; br = 0; busy = 0; inst = '0; rst_n = 0;
        #2;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("rst_ctl%0d", c), 32'(outs(c)), 32'(6'b011000));
            chk($sformatf("rst_scnt%0d", c), scnt(c), 0);
            chk($sformatf("rst_fcnt%0d", c), fcnt(c), 0);
            m_sc[c] = 0; m_fc[c] = 0;
            for (int k = 0; k < 3; k++) begin m_rd[c][k] = 0; m_ld[c][k] = 0; end
        end
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    initial begin
        logic [6:0] ops [9] = '{O_LOAD, O_STORE, O_BR, O_OP, O_IMM, O_JAL, O_JALR, O_LUI, O_AUIPC};
        @(posedge clk); #1;
        rst_pulse();
        // load-use: one bubble with forwarding
        cyc(1, enc(O_LOAD, 5, 1, 0), 0, 0);
        cyc(1, enc(O_OP, 6, 5, 2), 0, 0);
        cyc(1, enc(O_OP, 6, 5, 2), 0, 0);
        cyc(0, '0, 0, 0);
        chk("t1_stall_cnt", if1.stall_cnt, 1);
        // x0 destination and unused rs2 never stall
        rst_pulse();
        cyc(1, enc(O_LOAD, 0, 1, 0), 0, 0);
        cyc(1, enc(O_OP, 6, 0, 2), 0, 0);
        cyc(1, enc(O_LOAD, 5, 1, 0), 0, 0);
        cyc(1, enc(O_IMM, 7, 8, 5), 0, 0);
        cyc(0, '0, 0, 0);
        chk("t2_stall_cnt", if1.stall_cnt, 0);
        // taken branch beats a pending load-use stall
        rst_pulse();
        cyc(1, enc(O_LOAD, 5, 1, 0), 0, 0);
        cyc(1, enc(O_OP, 6, 5, 2), 1, 0);
        cyc(0, '0, 0, 0);
        chk("t3_flush_cnt", if1.flush_cnt, 1);
        chk("t3_stall_cnt", if1.stall_cnt, 0);
        // freeze holds branch and shadows, flush follows release
        rst_pulse();
        cyc(1, enc(O_LOAD, 5, 1, 0), 0, 0);
        repeat (3) cyc(1, enc(O_OP, 6, 5, 2), 1, 1);
        cyc(1, enc(O_OP, 6, 5, 2), 1, 0);
        cyc(1, enc(O_LOAD, 5, 1, 0), 0, 0);
        repeat (3) cyc(1, enc(O_OP, 6, 5, 2), 0, 1);
        cyc(1, enc(O_OP, 6, 5, 2), 0, 0);
        cyc(0, '0, 0, 0);
        chk("t4_flush_cnt", if1.flush_cnt, 1);
        chk("t4_stall_cnt", if1.stall_cnt, 1);
        // no forwarding: three bubbles, then reset mid-stall
        rst_pulse();
        cyc(1, enc(O_OP, 5, 1, 2), 0, 0);
        repeat (4) cyc(1, enc(O_OP, 6, 5, 3), 0, 0);
        chk("t5_stall_cnt", if0.stall_cnt, 3);
        cyc(1, enc(O_OP, 5, 1, 2), 0, 0);
        cyc(1, enc(O_OP, 6, 5, 3), 0, 0);
        rst_pulse();
        // saturation of a 4-bit counter
        repeat (20) begin
            cyc(1, enc(O_LOAD, 5, 1, 0), 0, 0);
            cyc(1, enc(O_OP, 6, 5, 2), 0, 0);
            cyc(1, enc(O_OP, 6, 5, 2), 0, 0);
        end
        chk("t6_sat4", if4.stall_cnt, 15);
        chk("t6_cnt16", if1.stall_cnt, 20);
        // random traffic with small register range to provoke hazards
        rst_pulse();
        for (int n = 0; n < 500; n++) begin
            logic [31:0] r = $urandom;
            r[6:0]   = ops[$urandom_range(0, 8)];
            r[11:7]  = 5'($urandom_range(0, 7));
            r[19:15] = 5'($urandom_range(0, 7));
            r[24:20] = 5'($urandom_range(0, 7));
            cyc(1'($urandom_range(0, 9) != 0), r, 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 6) == 0));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
